// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and UART-TX-side signals of the TX arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_par_en;
    logic [N_REQ-1:0]            req_par_typ;
    logic [N_REQ-1:0]            gnt;
    logic [DATA_WIDTH-1:0]       par_data;
    logic                        data_valid;
    logic                        par_en;
    logic                        par_typ;
    logic                        busy;
    logic                        arb_busy;

    // master: the clients plus the UART TX; slave: the arbiter itself
    modport master (
        output req, req_data, req_par_en, req_par_typ, busy,
        input  gnt, par_data, data_valid, par_en, par_typ, arb_busy
    );

    modport slave (
        input  req, req_data, req_par_en, req_par_typ, busy,
        output gnt, par_data, data_valid, par_en, par_typ, arb_busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter / frame sequencer sharing one UART TX among
//            N_REQ byte sources. Optional UART_ARB_STATS_EN adds frame_cnt
//            and drop_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
`ifdef UART_ARB_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int         c_ptr_w     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0] c_wait_last = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ptr_w-1:0]    r_ptr;
    logic [c_ptr_w-1:0]    r_winner;
    logic [c_ptr_w-1:0]    w_pick;
    logic [c_ptr_w-1:0]    w_idx;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_pick_data;
    logic [DATA_WIDTH-1:0] r_par_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [1:0]            r_wait_cnt;
    logic                  w_load;
    logic                  w_drop;

    // First active request scanning upward from the pointer, wrapping at N_REQ
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = c_ptr_w'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_pick_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_pick == c_ptr_w'(k)) begin
                w_pick_data = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !bus.busy) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // TX never acknowledged the frame: give up after four cycles
                if (bus.busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_state_nxt = S_IDLE;
                    w_drop      = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_winner   <= '0;
            r_par_data <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_load) begin
                r_winner   <= w_pick;
                r_par_data <= w_pick_data;
                r_par_en   <= bus.req_par_en[w_pick];
                r_par_typ  <= bus.req_par_typ[w_pick];
            end
            if (r_state == S_ISSUE) begin
                r_ptr      <= (r_winner == c_ptr_w'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT_BUSY) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.data_valid = (r_state == S_ISSUE);
    assign bus.gnt        = (r_state == S_ISSUE) ? (N_REQ'(1) << r_winner) : '0;
    assign bus.par_data   = r_par_data;
    assign bus.par_en     = r_par_en;
    assign bus.par_typ    = r_par_typ;
    assign bus.arb_busy   = (r_state != S_IDLE);

`ifdef UART_ARB_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drop_cnt;

    // frame count wraps; drop count saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`endif

endmodule

`default_nettype wire
